// File: rtl/tt_um_mux_sel_ctrl.sv
// Select-control stage for the two-input mux tile: synchronised, debounced select
// request driving a break-before-make sequencer with one-hot-or-zero channel enables.
module tt_um_mux_sel_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned GAP_CYCLES      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned DB_W  = 4;
    localparam int unsigned GAP_W = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ST_W  = 4;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    localparam logic [ST_W-1:0] S_SEL_A = 4'b0001;
    localparam logic [ST_W-1:0] S_BRK_B = 4'b0010;
    localparam logic [ST_W-1:0] S_SEL_B = 4'b0100;
    localparam logic [ST_W-1:0] S_BRK_A = 4'b1000;

    logic             r_req_m;
    logic             r_req_s;
    logic             r_hold_m;
    logic             r_hold_s;
    logic             r_req_stable;
    logic [DB_W-1:0]  r_db_cnt;
    logic [ST_W-1:0]  r_state;
    logic [GAP_W-1:0] r_gap;
    logic [CNT_W-1:0] r_sw_cnt;
    logic             r_mux_q;

    logic [ST_W-1:0]  w_state_nxt;
    logic             w_gap_load;
    logic             w_gap_dec;
    logic             w_sw_inc;
    logic             w_mux_d;
    logic             w_busy;
    logic             w_unused;

    // Two-flop synchronisers for the pad-level select and hold requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_m  <= 1'b0;
            r_req_s  <= 1'b0;
            r_hold_m <= 1'b0;
            r_hold_s <= 1'b0;
        end else if (ena) begin
            r_req_m  <= ui_in[0];
            r_req_s  <= r_req_m;
            r_hold_m <= ui_in[3];
            r_hold_s <= r_hold_m;
        end
    end

    // Debounce: any cycle of agreement restarts the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_stable <= 1'b0;
            r_db_cnt     <= '0;
        end else if (ena) begin
            if (r_req_s == r_req_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_req_stable <= r_req_s;
                r_db_cnt     <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_SEL_A;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SEL_A: if (r_req_stable && !r_hold_s)  w_state_nxt = S_BRK_B;
            S_BRK_B: if (r_gap == '0)                w_state_nxt = S_SEL_B;
            S_SEL_B: if (!r_req_stable && !r_hold_s) w_state_nxt = S_BRK_A;
            S_BRK_A: if (r_gap == '0)                w_state_nxt = S_SEL_A;
            default:                                 w_state_nxt = S_SEL_A;
        endcase
    end

    // Per-state datapath controls; break states force the muxed bit low
    always_comb begin
        w_gap_load = 1'b0;
        w_gap_dec  = 1'b0;
        w_sw_inc   = 1'b0;
        w_mux_d    = 1'b0;
        case (r_state)
            S_SEL_A: begin
                w_mux_d    = ui_in[1];
                w_gap_load = (w_state_nxt == S_BRK_B);
            end
            S_SEL_B: begin
                w_mux_d    = ui_in[2];
                w_gap_load = (w_state_nxt == S_BRK_A);
            end
            S_BRK_A, S_BRK_B: begin
                w_gap_dec = (r_gap != '0);
                w_sw_inc  = (r_gap == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap    <= '0;
            r_sw_cnt <= '0;
            r_mux_q  <= 1'b0;
        end else if (ena) begin
            if (w_gap_load) begin
                r_gap <= GAP_LOAD;
            end else if (w_gap_dec) begin
                r_gap <= r_gap - GAP_W'(1);
            end
            if (w_sw_inc) begin
                r_sw_cnt <= r_sw_cnt + CNT_W'(1);
            end
            r_mux_q <= w_mux_d;
        end
    end

    assign w_busy   = r_state[1] | r_state[3];
    assign uo_out   = {r_sw_cnt, w_busy, r_mux_q, r_state[2], r_state[0]};
    assign uio_out  = '0;
    assign uio_oe   = '0;
    assign w_unused = &{1'b0, uio_in, ui_in[7:4]};

endmodule

// File: tb/tb_tt_um_mux_sel_ctrl.sv
// Scoreboard bench for tt_um_mux_sel_ctrl: directed stimulus queues expected uo_out
// values tagged with the cycle they are due; a negedge monitor pops and compares.
module tb_tt_um_mux_sel_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        int         due;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    tt_um_mux_sel_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input string name, input int due, input logic [7:0] exp);
        exp_t e;
        e.due  = due;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: invariants every cycle, scoreboard entries when due
    always @(negedge clk) begin
        exp_t e;
        n_total++;
        if (uio_out == 8'h00 && uio_oe == 8'h00) n_pass++;
        else $display("FAIL uio_const cyc=%0d uio_out=%h uio_oe=%h required 00/00", cyc, uio_out, uio_oe);
        n_total++;
        if (!(uo_out[0] && uo_out[1])) n_pass++;
        else $display("FAIL sel_overlap cyc=%0d uo_out=%b", cyc, uo_out);
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_total++;
            if (e.due < cyc)
                $display("FAIL %s missed: due cyc %0d, now %0d", e.name, e.due, cyc);
            else if (uo_out === e.exp)
                n_pass++;
            else
                $display("FAIL %s cyc=%0d uo_out=%b required %b", e.name, cyc, uo_out, e.exp);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        step(2);
        rst_n = 1'b1;
        push("reset_state", cyc, 8'h01);

        // A data follows into mux_q with one cycle latency in SEL_A
        base  = cyc;
        ui_in = 8'h02;
        push("muxA_hi", base + 1, 8'h05);
        push("muxA_lo", base + 2, 8'h01);
        step(1);
        ui_in = 8'h00;
        step(2);

        // 5-cycle glitch never reaches req_stable
        base  = cyc;
        ui_in = 8'h01;
        push("glitch_mid", base + 8, 8'h01);
        push("glitch_end", base + 15, 8'h01);
        step(5);
        ui_in = 8'h00;
        step(11);

        // Clean switch A->B with both data bits high, then B data drops
        base  = cyc;
        ui_in = 8'h07;
        push("sw_pre",     base + 10, 8'h05);
        push("sw_brk1",    base + 11, 8'h0C);
        push("sw_brk2",    base + 12, 8'h08);
        push("sw_selb",    base + 13, 8'h12);
        push("sw_muxB_hi", base + 14, 8'h16);
        push("sw_muxB_lo", base + 15, 8'h12);
        step(14);
        ui_in = 8'h03;
        step(1);

        // Hold blocks the return switch; release starts it one cycle after hold_s falls
        base  = cyc;
        ui_in = 8'h08;
        push("hold_stay", base + 20, 8'h12);
        step(20);
        base  = cyc;
        ui_in = 8'h00;
        push("rel_wait",  base + 2, 8'h12);
        push("rel_brk1",  base + 3, 8'h18);
        push("rel_brk2",  base + 4, 8'h18);
        push("rel_sela",  base + 5, 8'h21);
        step(5);

        // Request withdrawn during BRK_B: completes to SEL_B, then returns
        base  = cyc;
        ui_in = 8'h01;
        push("rev_brk",    base + 11, 8'h28);
        push("rev_selb",   base + 13, 8'h32);
        push("rev_hold",   base + 21, 8'h32);
        push("rev_brka1",  base + 22, 8'h38);
        push("rev_brka2",  base + 23, 8'h38);
        push("rev_sela",   base + 24, 8'h41);
        step(11);
        ui_in = 8'h00;
        step(13);

        // ena low for 4 cycles inside BRK_B delays SEL_B from edge 13 to 17
        base  = cyc;
        ui_in = 8'h01;
        push("ena_brk",    base + 11, 8'h48);
        push("ena_nom13",  base + 13, 8'h48);
        push("ena_frz",    base + 15, 8'h48);
        push("ena_brk16",  base + 16, 8'h48);
        push("ena_selb17", base + 17, 8'h52);
        step(11);
        ena = 1'b0;
        step(4);
        ena = 1'b1;
        step(6);

        // Eleven more switches bring sw_cnt through 15 back to 0
        for (int i = 0; i < 11; i++) begin
            logic [3:0] cnt;
            logic       req;
            base  = cyc;
            req   = (i % 2 == 1);
            cnt   = 4'((6 + i) % 16);
            ui_in = {7'b0, req};
            push($sformatf("wrap_%0d", i), base + 13, {cnt, 2'b00, req, ~req});
            step(14);
        end

        // Async reset inside BRK_B, then the full latency repeats
        base  = cyc;
        ui_in = 8'h01;
        push("rst_brk", base + 11, 8'h08);
        step(12);
        rst_n = 1'b0;
        push("rst_async", cyc, 8'h01);
        step(2);
        push("rst_held", cyc, 8'h01);
        rst_n = 1'b1;
        base  = cyc;
        push("rst_pre",  base + 10, 8'h01);
        push("rst_brk2", base + 11, 8'h08);
        push("rst_selb", base + 13, 8'h12);
        step(15);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_total++;
            $display("FAIL %s never checked: due cyc %0d, end cyc %0d", e.name, e.due, cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
